pp_tree9_pipe: RTL and testbench

Parametrised, pipelined 9-row partial-product reduction tree with a valid/ready stream interface. It sits between the partial-product generator and the multiplier output. It reduces nine W-bit rows, using 4:2 and 3:2 carry-save stages, either to a redundant sum/carry pair or, through an optional final carry-propagate adder, to a resolved result. Stage registers are selectable per stage, so one block serves both single-cycle and pipelined multiplier builds.

---
 rtl/pp_tree9_pipe.sv | 163 ++++++++++++++++
 tb/tb_pp_tree9_pipe.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_tree9_pipe.sv
// pp_tree9_pipe: nine-row carry-save reduction (4:2 / 3:2 cells) with optional CPA.
// Each stage boundary can be an elastic {valid, data, tag} slot or a plain wire.
module pp_tree9_pipe #(
    parameter int         W         = 32,
    parameter int         MODE      = 1,
    parameter logic [2:0] STAGE_REG = 3'b111,
    parameter int         TAG_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [9*W-1:0]     pp_i,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       res_o,
    output logic [W-1:0]       car_o,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int D1  = 4*W + TAG_W;
    localparam int D2  = 2*W + TAG_W;
    localparam bit EN1 = STAGE_REG[0];
    localparam bit EN2 = STAGE_REG[1];
    localparam bit EN3 = STAGE_REG[2] && (MODE == 1);

    // Returns {carry, sum}; the carry word is unshifted, the bit leaving W-1 is dropped by the caller's shift.
    function automatic logic [2*W-1:0] csa42(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] c, input logic [W-1:0] d);
        logic [W-1:0] sm;
        logic [W-1:0] cy;
        logic         s1;
        logic         co;
        logic         ci;
        ci = 1'b0;
        for (int i = 0; i < W; i++) begin
            s1    = a[i] ^ b[i] ^ c[i];
            co    = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
            sm[i] = s1 ^ d[i] ^ ci;
            cy[i] = (s1 & d[i]) | (s1 & ci) | (d[i] & ci);
            ci    = co;
        end
        return {cy, sm};
    endfunction

    function automatic logic [2*W-1:0] csa32(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    logic [2*W-1:0] w_grp_a;
    logic [2*W-1:0] w_grp_b;
    logic [2*W-1:0] w_grp_c;
    logic [2*W-1:0] w_grp_d;
    logic [D1-1:0]  w_d1_in;
    logic [D1-1:0]  w_d1;
    logic [D2-1:0]  w_d2_in;
    logic [D2-1:0]  w_d2;
    logic [D2-1:0]  w_d3_in;
    logic [D2-1:0]  w_d3;
    logic           w_v1;
    logic           w_v2;
    logic           w_rdy1;
    logic           w_rdy2;

    // stage 1: two 4:2 groups, then fold P8 into the low group with a 3:2
    always_comb begin
        w_grp_a = csa42(pp_i[0*W +: W], pp_i[1*W +: W], pp_i[2*W +: W], pp_i[3*W +: W]);
        w_grp_b = csa42(pp_i[4*W +: W], pp_i[5*W +: W], pp_i[6*W +: W], pp_i[7*W +: W]);
        w_grp_c = csa32(w_grp_a[W-1:0], w_grp_a[2*W-1:W] << 1, pp_i[8*W +: W]);
        w_d1_in = {in_tag, w_grp_c[W-1:0], w_grp_c[2*W-1:W] << 1,
                   w_grp_b[W-1:0], w_grp_b[2*W-1:W] << 1};
    end

    generate
        if (EN1) begin : g_slot_p0
            logic          r_vld_p0;
            logic [D1-1:0] r_dat_p0;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_vld_p0 <= 1'b0;
                    r_dat_p0 <= '0;
                end else if (in_ready) begin
                    r_vld_p0 <= in_valid;
                    if (in_valid) r_dat_p0 <= w_d1_in;
                end
            end
            assign in_ready = !r_vld_p0 || w_rdy1 || !rst_n;
            assign w_v1     = r_vld_p0;
            assign w_d1     = r_dat_p0;
        end else begin : g_wire_p0
            assign in_ready = w_rdy1;
            assign w_v1     = in_valid;
            assign w_d1     = w_d1_in;
        end
    endgenerate

    // stage 2: final 4:2 merges both groups into one sum/carry pair
    always_comb begin
        w_grp_d = csa42(w_d1[4*W-1 -: W], w_d1[3*W-1 -: W], w_d1[2*W-1 -: W], w_d1[W-1:0]);
        w_d2_in = {w_d1[D1-1 -: TAG_W], w_grp_d[W-1:0], w_grp_d[2*W-1:W] << 1};
    end

    generate
        if (EN2) begin : g_slot_p1
            logic          r_vld_p1;
            logic [D2-1:0] r_dat_p1;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_vld_p1 <= 1'b0;
                    r_dat_p1 <= '0;
                end else if (w_rdy1) begin
                    r_vld_p1 <= w_v1;
                    if (w_v1) r_dat_p1 <= w_d2_in;
                end
            end
            assign w_rdy1 = !r_vld_p1 || w_rdy2 || !rst_n;
            assign w_v2   = r_vld_p1;
            assign w_d2   = r_dat_p1;
        end else begin : g_wire_p1
            assign w_rdy1 = w_rdy2;
            assign w_v2   = w_v1;
            assign w_d2   = w_d2_in;
        end
    endgenerate

    // stage 3: carry-propagate add in resolved mode, redundant pair otherwise
    always_comb begin
        w_d3_in = w_d2;
        if (MODE == 1) begin
            w_d3_in = {w_d2[D2-1 -: TAG_W], w_d2[2*W-1 -: W] + w_d2[W-1:0], {W{1'b0}}};
        end
    end

    generate
        if (EN3) begin : g_slot_p2
            logic          r_vld_p2;
            logic [D2-1:0] r_dat_p2;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_vld_p2 <= 1'b0;
                    r_dat_p2 <= '0;
                end else if (w_rdy2) begin
                    r_vld_p2 <= w_v2;
                    if (w_v2) r_dat_p2 <= w_d3_in;
                end
            end
            assign w_rdy2    = !r_vld_p2 || out_ready || !rst_n;
            assign out_valid = r_vld_p2;
            assign w_d3      = r_dat_p2;
        end else begin : g_wire_p2
            assign w_rdy2    = out_ready;
            assign out_valid = w_v2;
            assign w_d3      = w_d3_in;
        end
    endgenerate

    assign out_tag = w_d3[D2-1 -: TAG_W];
    assign res_o   = w_d3[2*W-1 -: W];
    assign car_o   = w_d3[W-1:0];

endmodule

// File: tb/tb_pp_tree9_pipe.sv
// Bench for pp_tree9_pipe: pipelined resolved build (W=32) plus a
// purely combinational redundant build (W=16).
module tb_pp_tree9_pipe;

    localparam int W  = 32;
    localparam int W2 = 16;
    localparam int TW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              in_valid, in_ready, out_valid, out_ready;
    logic [9*W-1:0]    pp;
    logic [TW-1:0]     in_tag, out_tag;
    logic [W-1:0]      res, car;

    logic              v2, rdy2, ov2, ordy2;
    logic [9*W2-1:0]   pp2;
    logic [TW-1:0]     t2, ot2;
    logic [W2-1:0]     res2, car2;

    pp_tree9_pipe #(.W(W), .MODE(1), .STAGE_REG(3'b111), .TAG_W(TW)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pp_i(pp), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .res_o(res), .car_o(car), .out_tag(out_tag)
    );

    pp_tree9_pipe #(.W(W2), .MODE(0), .STAGE_REG(3'b000), .TAG_W(TW)) u_comb (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
        .pp_i(pp2), .in_tag(t2), .out_valid(ov2), .out_ready(ordy2),
        .res_o(res2), .car_o(car2), .out_tag(ot2)
    );

    typedef struct packed {
        logic [9*W-1:0] rows;
        logic [TW-1:0]  tag;
        logic [W-1:0]   exp_res;
        logic [W-1:0]   exp_car;
    } vec_t;

    typedef struct packed {
        logic [W-1:0]  res;
        logic [W-1:0]  car;
        logic [TW-1:0] tag;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    int   out_cyc[$];
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    function automatic logic [W-1:0] ref32(input logic [9*W-1:0] r);
        logic [W-1:0] s;
        s = '0;
        for (int k = 0; k < 9; k++) s = s + r[k*W +: W];
        return s;
    endfunction

    function automatic logic [W2-1:0] ref16(input logic [9*W2-1:0] r);
        logic [W2-1:0] s;
        s = '0;
        for (int k = 0; k < 9; k++) s = s + r[k*W2 +: W2];
        return s;
    endfunction

    function automatic logic [9*W-1:0] rnd_rows();
        logic [9*W-1:0] r;
        for (int k = 0; k < 9; k++) r[k*W +: W] = $urandom();
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output scoreboard: every transfer must match the oldest outstanding expectation.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            out_cyc.push_back(cyc);
            n_out++;
            if (exp_q.size() == 0) begin
                chk("spurious out_valid", {63'b0, out_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("res_o", res, e.res);
                chk("car_o", car, e.car);
                chk("out_tag", out_tag, e.tag);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge, in_valid left high.
    task automatic send(input logic [9*W-1:0] r, input logic [TW-1:0] t,
                        input logic [W-1:0] e_res, input logic [W-1:0] e_car);
        exp_t x;
        in_valid = 1'b1;
        pp       = r;
        in_tag   = t;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                x.res = e_res;
                x.car = e_car;
                x.tag = t;
                exp_q.push_back(x);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        chk("accept timeout", {63'b0, in_ready}, 64'd1);
    endtask

    task automatic wait_lat(input string nm, input int req);
        int lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk(nm, lat, req);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
        chk("drain pending", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int             n0, s0, idx, last_rdy;
        logic           pv;
        logic [W-1:0]   h_res, h_car;
        logic [TW-1:0]  h_tag;
        logic [9*W-1:0] r;
        logic [9*W-1:0] bp[6];
        logic [W2-1:0]  sum2;

        for (int i = 0; i < 7; i++) begin
            tbl[i].rows    = '0;
            tbl[i].exp_car = '0;
        end
        tbl[0].rows[0*W +: W] = 32'd5;
        tbl[0].rows[8*W +: W] = 32'd7;
        tbl[0].tag = 4'd3;  tbl[0].exp_res = 32'd12;
        tbl[1].rows = {9{32'hFFFF_FFFF}};
        tbl[1].tag = 4'd5;  tbl[1].exp_res = 32'hFFFF_FFF7;
        for (int k = 0; k < 9; k++) tbl[2].rows[k*W +: W] = 32'(k + 1);
        tbl[2].tag = 4'd1;  tbl[2].exp_res = 32'd45;
        for (int k = 0; k < 9; k++) tbl[3].rows[k*W +: W] = 32'd1 << (3*k);
        tbl[3].tag = 4'd2;  tbl[3].exp_res = 32'h0124_9249;
        tbl[4].rows[0*W +: W] = 32'h8000_0000;
        tbl[4].rows[1*W +: W] = 32'h8000_0000;
        tbl[4].tag = 4'd4;  tbl[4].exp_res = 32'h0000_0000;
        tbl[5].rows[0*W +: W] = 32'h1234_5678;
        tbl[5].rows[7*W +: W] = 32'h1111_1111;
        tbl[5].rows[8*W +: W] = 32'hEDCB_A987;
        tbl[5].tag = 4'd6;  tbl[5].exp_res = 32'h1111_1110;
        tbl[6].rows = {9{32'h7FFF_FFFF}};
        tbl[6].tag = 4'd7;  tbl[6].exp_res = 32'h7FFF_FFF7;

        rst_n = 1'b0; in_valid = 1'b0; pp = '0; in_tag = '0; out_ready = 1'b1;
        v2 = 1'b0; ordy2 = 1'b0; pp2 = '0; t2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", {63'b0, out_valid}, 64'd0);
        chk("reset res_o", res, 64'd0);
        chk("reset car_o", car, 64'd0);
        chk("reset out_tag", out_tag, 64'd0);
        chk("reset in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            send(tbl[i].rows, tbl[i].tag, tbl[i].exp_res, tbl[i].exp_car);
            in_valid = 1'b0;
            wait_lat($sformatf("latency vec%0d", i), 3);
        end

        s0 = out_cyc.size();
        n0 = n_out;
        for (int i = 0; i < 8; i++) begin
            r = rnd_rows();
            send(r, 4'(i), ref32(r), '0);
        end
        in_valid = 1'b0;
        drain();
        chk("stream count", n_out - n0, 8);
        if (out_cyc.size() >= s0 + 8)
            chk("stream back-to-back", out_cyc[s0+7] - out_cyc[s0], 7);
        else
            chk("stream outputs seen", out_cyc.size() - s0, 8);

        // Backpressure: five stalled cycles with a continuously offered stream.
        for (int i = 0; i < 6; i++) bp[i] = rnd_rows();
        n0 = n_out; idx = 0; pv = 1'b0; last_rdy = 1;
        h_res = '0; h_car = '0; h_tag = '0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        pp        = bp[0];
        in_tag    = 4'd8;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (pv && out_valid) begin
                chk("stall hold res_o", res, h_res);
                chk("stall hold car_o", car, h_car);
                chk("stall hold out_tag", out_tag, h_tag);
            end
            pv = out_valid; h_res = res; h_car = car; h_tag = out_tag;
            last_rdy = int'(in_ready);
            if (in_ready) begin
                exp_q.push_back('{res: ref32(bp[idx]), car: '0, tag: 4'(8 + idx)});
                idx++;
            end
            @(posedge clk);
            #1;
            pp     = bp[idx];
            in_tag = 4'(8 + idx);
        end
        chk("accepted while stalled", idx, 3);
        chk("in_ready when full", last_rdy, 0);
        out_ready = 1'b1;
        for (int i = idx; i < 6; i++) send(bp[i], 4'(8 + i), ref32(bp[i]), '0);
        in_valid = 1'b0;
        drain();
        chk("stall delivered", n_out - n0, 6);

        // Reset with two transactions in flight and one offered during reset.
        send(rnd_rows(), 4'd1, '0, '0);
        send(rnd_rows(), 4'd2, '0, '0);
        rst_n = 1'b0;
        exp_q.delete();
        pp = rnd_rows();
        in_tag = 4'd15;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        n0 = n_out;
        @(negedge clk);
        chk("post-reset out_valid", {63'b0, out_valid}, 64'd0);
        chk("post-reset res_o", res, 64'd0);
        chk("post-reset out_tag", out_tag, 64'd0);
        repeat (8) @(negedge clk);
        chk("no output after reset", n_out - n0, 0);
        @(posedge clk);
        #1;
        r = rnd_rows();
        send(r, 4'd9, ref32(r), '0);
        in_valid = 1'b0;
        wait_lat("latency after reset", 3);
        drain();

        // Combinational redundant build.
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 9; k++) pp2[k*W2 +: W2] = (i == 0) ? 16'hFFFF : 16'($urandom());
            t2    = 4'($urandom());
            v2    = 1'($urandom());
            ordy2 = 1'($urandom());
            @(negedge clk);
            sum2 = res2 + car2;
            chk("comb out_valid", {63'b0, ov2}, {63'b0, v2});
            chk("comb in_ready", {63'b0, rdy2}, {63'b0, ordy2});
            chk("comb sum", sum2, ref16(pp2));
            chk("comb tag", ot2, t2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
